// File: rtl/wb_stage_lsq.sv
// wb_stage_lsq: merges ALU results and tracked out-of-order-latency load responses onto one register write port
module wb_stage_lsq #(
    parameter int XLEN = 32,
    parameter int DEPTH = 4,
    parameter int RA_W = 5,
    localparam int OFS_W = $clog2(XLEN / 8),
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [RA_W-1:0]  ex_rd,
    input  logic             ex_reg_w_en,
    input  logic             ex_is_load,
    input  logic [2:0]       ex_f3,
    input  logic [OFS_W-1:0] ex_ofs,
    input  logic [XLEN-1:0]  ex_alu_out,
    input  logic             mem_rsp_valid,
    input  logic [XLEN-1:0]  mem_rsp_data,
    output logic             wb_en,
    output logic [RA_W-1:0]  wb_reg,
    output logic [XLEN-1:0]  wb_val,
    output logic [CW-1:0]    pend_cnt,
    output logic             rsp_err
);
    logic [RA_W-1:0]  rd_q [DEPTH];
    logic [RA_W-1:0]  rd_d [DEPTH];
    logic [2:0]       f3_q [DEPTH];
    logic [2:0]       f3_d [DEPTH];
    logic [OFS_W-1:0] ofs_q [DEPTH];
    logic [OFS_W-1:0] ofs_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             wb_en_q, wb_en_d, rsp_err_q, rsp_err_d;
    logic [RA_W-1:0]  wb_reg_q, wb_reg_d;
    logic [XLEN-1:0]  wb_val_q, wb_val_d, ld_val;
    logic             waw, alu_w, push, pop, alu_acc, full, empty;
    logic [RA_W-1:0]  hd_rd;
    logic [2:0]       hd_f3;
    logic [OFS_W-1:0] hd_ofs;
    logic [7:0]       b8;
    logic [15:0]      h16;
    logic [31:0]      w32;

    assign full  = cnt_q == CW'(DEPTH);
    assign empty = cnt_q == '0;
    assign alu_w = ex_reg_w_en & ~ex_is_load;
    assign hd_rd  = rd_q[head_q];
    assign hd_f3  = f3_q[head_q];
    assign hd_ofs = ofs_q[head_q];

    always_comb begin
        waw = 1'b0;
        for (int i = 0; i < DEPTH; i++) waw = waw | (vld_q[i] & (rd_q[i] == ex_rd));
    end

    // response owns the port; WAW stall keeps a younger ALU write from being overwritten by an older load
    assign ex_ready = ~((ex_is_load & full) | (alu_w & mem_rsp_valid) | (alu_w & (ex_rd != '0) & waw));
    assign push    = ex_valid & ex_ready & ex_is_load;
    assign alu_acc = ex_valid & ex_ready & alu_w;
    assign pop     = mem_rsp_valid & ~empty;

    assign b8  = 8'(mem_rsp_data >> {hd_ofs, 3'b000});
    assign h16 = 16'(mem_rsp_data >> {hd_ofs[OFS_W-1:1], 4'b0000});
    assign w32 = XLEN == 64 ? 32'(mem_rsp_data >> {hd_ofs[OFS_W-1], 5'b00000}) : 32'(mem_rsp_data);

    always_comb begin
        ld_val = hd_f3 == 3'b000 ? XLEN'($signed(b8)) :
                 hd_f3 == 3'b001 ? XLEN'($signed(h16)) :
                 hd_f3 == 3'b010 ? XLEN'($signed(w32)) :
                 hd_f3 == 3'b011 ? (XLEN == 64 ? mem_rsp_data : '0) :
                 hd_f3 == 3'b100 ? XLEN'(b8) :
                 hd_f3 == 3'b101 ? XLEN'(h16) :
                 hd_f3 == 3'b110 ? (XLEN == 64 ? XLEN'(w32) : '0) : '0;
    end

    always_comb begin
        rd_d   = rd_q;
        f3_d   = f3_q;
        ofs_d  = ofs_q;
        vld_d  = vld_q;
        head_d = pop ? head_q + PW'(1) : head_q;
        tail_d = push ? tail_q + PW'(1) : tail_q;
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
        if (pop) vld_d[head_q] = 1'b0;
        if (push) begin
            vld_d[tail_q] = 1'b1;
            rd_d[tail_q]  = ex_rd;
            f3_d[tail_q]  = ex_f3;
            ofs_d[tail_q] = ex_ofs;
        end
        wb_en_d   = pop ? hd_rd != '0 : alu_acc & (ex_rd != '0);
        wb_reg_d  = pop ? hd_rd : alu_acc ? ex_rd : '0;
        wb_val_d  = pop ? ld_val : alu_acc ? ex_alu_out : '0;
        rsp_err_d = rsp_err_q | (mem_rsp_valid & empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q     <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= '0;
            wb_en_q   <= 1'b0;
            wb_reg_q  <= '0;
            wb_val_q  <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            vld_q     <= vld_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            cnt_q     <= cnt_d;
            wb_en_q   <= wb_en_d;
            wb_reg_q  <= wb_reg_d;
            wb_val_q  <= wb_val_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    always_ff @(posedge clk) begin
        rd_q  <= rd_d;
        f3_q  <= f3_d;
        ofs_q <= ofs_d;
    end

    assign wb_en    = wb_en_q;
    assign wb_reg   = wb_reg_q;
    assign wb_val   = wb_val_q;
    assign pend_cnt = cnt_q;
    assign rsp_err  = rsp_err_q;
endmodule

// File: tb/tb_wb_stage_lsq.sv
// tb_wb_stage_lsq: directed vectors with hand-computed expectations for wb_stage_lsq (XLEN=32, DEPTH=4)
module tb_wb_stage_lsq;
    logic        clk = 1'b0;
    logic        rst, ex_valid, ex_ready, ex_reg_w_en, ex_is_load, mem_rsp_valid;
    logic        wb_en, rsp_err;
    logic [4:0]  ex_rd, wb_reg;
    logic [2:0]  ex_f3, pend_cnt;
    logic [1:0]  ex_ofs;
    logic [31:0] ex_alu_out, mem_rsp_data, wb_val;
    int          checks = 0;
    int          errors = 0;

    wb_stage_lsq dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd),
        .ex_reg_w_en(ex_reg_w_en), .ex_is_load(ex_is_load), .ex_f3(ex_f3), .ex_ofs(ex_ofs),
        .ex_alu_out(ex_alu_out), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_val(wb_val), .pend_cnt(pend_cnt), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        ex_valid = 1'b0;
        ex_reg_w_en = 1'b0;
        ex_is_load = 1'b0;
        mem_rsp_valid = 1'b0;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] v);
        ex_valid = 1'b1;
        ex_is_load = 1'b0;
        ex_reg_w_en = 1'b1;
        ex_rd = rd;
        ex_alu_out = v;
    endtask

    task automatic ld(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] ofs);
        ex_valid = 1'b1;
        ex_is_load = 1'b1;
        ex_reg_w_en = 1'b0;
        ex_rd = rd;
        ex_f3 = f3;
        ex_ofs = ofs;
    endtask

    task automatic rsp(input logic [31:0] d);
        mem_rsp_valid = 1'b1;
        mem_rsp_data = d;
    endtask

    task automatic wb(input string tag, input logic en, input logic [4:0] rg, input logic [31:0] v);
        check({tag, ".en"}, 32'(wb_en), 32'(en));
        if (en) begin
            check({tag, ".reg"}, 32'(wb_reg), 32'(rg));
            check({tag, ".val"}, wb_val, v);
        end
    endtask

    task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [1:0] ofs, input logic [31:0] d, input logic en, input logic [31:0] v);
        ld(rd, f3, ofs);
        #1 check({tag, ".rdy"}, 32'(ex_ready), 32'd1);
        tick;
        idle;
        check({tag, ".issue_en"}, 32'(wb_en), 32'd0);
        check({tag, ".pend1"}, 32'(pend_cnt), 32'd1);
        tick;
        rsp(d);
        tick;
        idle;
        wb(tag, en, rd, v);
        check({tag, ".pend0"}, 32'(pend_cnt), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ex_rd = '0; ex_f3 = '0; ex_ofs = '0; ex_alu_out = '0; mem_rsp_data = '0;
        idle;
        tick; tick;
        rst = 1'b0;
        #1;
        wb("reset", 1'b0, 5'd0, 32'd0);
        check("reset.reg", 32'(wb_reg), 32'd0);
        check("reset.val", wb_val, 32'd0);
        check("reset.pend", 32'(pend_cnt), 32'd0);
        check("reset.err", 32'(rsp_err), 32'd0);
        check("reset.rdy", 32'(ex_ready), 32'd1);

        alu(5'd5, 32'h1234_5678);
        #1 check("alu.rdy", 32'(ex_ready), 32'd1);
        tick;
        idle;
        wb("alu", 1'b1, 5'd5, 32'h1234_5678);
        tick;
        wb("alu.pulse", 1'b0, 5'd0, 32'd0);
        alu(5'd0, 32'hFFFF_FFFF);
        tick;
        idle;
        wb("alu.rd0", 1'b0, 5'd0, 32'd0);
        alu(5'd1, 32'hA);
        tick;
        alu(5'd2, 32'hB);
        wb("b2b.1", 1'b1, 5'd1, 32'hA);
        tick;
        idle;
        wb("b2b.2", 1'b1, 5'd2, 32'hB);

        do_load("lb",  5'd7, 3'b000, 2'd2, 32'h0080_0000, 1'b1, 32'hFFFF_FF80);
        do_load("lbu", 5'd7, 3'b100, 2'd2, 32'h0080_0000, 1'b1, 32'h0000_0080);
        do_load("lh",  5'd7, 3'b001, 2'd2, 32'h8001_0000, 1'b1, 32'hFFFF_8001);
        do_load("lhu", 5'd8, 3'b101, 2'd1, 32'h0000_F00D, 1'b1, 32'h0000_F00D);
        do_load("lw",  5'd3, 3'b010, 2'd3, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF);
        do_load("ld32", 5'd4, 3'b011, 2'd0, 32'hFFFF_FFFF, 1'b1, 32'h0);
        do_load("ldrd0", 5'd0, 3'b010, 2'd0, 32'h1111_1111, 1'b0, 32'h0);

        for (int i = 0; i < 4; i++) begin
            ld(5'(10 + i), 3'b010, 2'd0);
            tick;
        end
        ld(5'd14, 3'b010, 2'd0);
        #1 check("full.pend", 32'(pend_cnt), 32'd4);
        check("full.rdy", 32'(ex_ready), 32'd0);
        rsp(32'hAAAA_0001);
        #1 check("full.rdy_pop", 32'(ex_ready), 32'd0);
        tick;
        mem_rsp_valid = 1'b0;
        wb("full.pop", 1'b1, 5'd10, 32'hAAAA_0001);
        check("full.pend3", 32'(pend_cnt), 32'd3);
        #1 check("full.rdy_after", 32'(ex_ready), 32'd1);
        tick;
        idle;
        check("full.pend_re", 32'(pend_cnt), 32'd4);
        for (int i = 0; i < 4; i++) begin
            rsp(32'(i + 100));
            tick;
            wb($sformatf("drain%0d", i), 1'b1, 5'(11 + i), 32'(i + 100));
        end
        idle;
        check("drain.pend", 32'(pend_cnt), 32'd0);

        ld(5'd9, 3'b010, 2'd0);
        tick;
        alu(5'd9, 32'h55);
        #1 check("waw.rdy", 32'(ex_ready), 32'd0);
        ex_rd = 5'd3;
        #1 check("waw.other_rd", 32'(ex_ready), 32'd1);
        ex_rd = 5'd9;
        tick;
        check("waw.hold_en", 32'(wb_en), 32'd0);
        check("waw.hold_rdy", 32'(ex_ready), 32'd0);
        rsp(32'h77);
        tick;
        mem_rsp_valid = 1'b0;
        wb("waw.load", 1'b1, 5'd9, 32'h77);
        #1 check("waw.rdy_after", 32'(ex_ready), 32'd1);
        tick;
        idle;
        wb("waw.alu", 1'b1, 5'd9, 32'h55);

        ld(5'd4, 3'b010, 2'd0);
        tick;
        alu(5'd6, 32'h66);
        rsp(32'h44);
        #1 check("prio.rdy", 32'(ex_ready), 32'd0);
        tick;
        mem_rsp_valid = 1'b0;
        wb("prio.load", 1'b1, 5'd4, 32'h44);
        #1 check("prio.rdy_after", 32'(ex_ready), 32'd1);
        tick;
        idle;
        wb("prio.alu", 1'b1, 5'd6, 32'h66);

        ld(5'd20, 3'b010, 2'd0);
        tick;
        ld(5'd21, 3'b010, 2'd0);
        rsp(32'h11);
        #1 check("pushpop.rdy", 32'(ex_ready), 32'd1);
        tick;
        idle;
        wb("pushpop.a", 1'b1, 5'd20, 32'h11);
        check("pushpop.pend", 32'(pend_cnt), 32'd1);
        rsp(32'h22);
        tick;
        idle;
        wb("pushpop.b", 1'b1, 5'd21, 32'h22);
        check("pushpop.pend0", 32'(pend_cnt), 32'd0);
        check("pushpop.err", 32'(rsp_err), 32'd0);

        rsp(32'h99);
        tick;
        idle;
        check("orphan.en", 32'(wb_en), 32'd0);
        check("orphan.err", 32'(rsp_err), 32'd1);
        tick; tick;
        check("orphan.sticky", 32'(rsp_err), 32'd1);

        ld(5'd8, 3'b010, 2'd0);
        tick;
        idle;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rst.pend", 32'(pend_cnt), 32'd0);
        check("rst.err", 32'(rsp_err), 32'd0);
        check("rst.rdy", 32'(ex_ready), 32'd1);
        rsp(32'h5A);
        tick;
        idle;
        check("rst.late_en", 32'(wb_en), 32'd0);
        check("rst.late_err", 32'(rsp_err), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_stage_lsq.md
# wb_stage_lsq

Parametrised writeback stage for the RV32/RV64 pipeline: merges ALU results and out-of-band memory load responses onto the single register-file write port. Loads issued by execute are tracked in an in-order pending queue, so memory may return data any number of cycles later. Load data is lane-selected by address offset and sign- or zero-extended per funct3. The stage throttles execute through a ready handshake for queue-full and write-after-write hazards.

## Interface
- XLEN, 32, datapath width; 32 or 64 only
- DEPTH, 4, max outstanding loads; power of two, ≥2
- RA_W, 5, register address width
- OFS_W, derived log2(XLEN/8), byte-offset width
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  execute presents an op
- ex_ready  out  1  stage accepts op this cycle
- ex_rd  in  RA_W  destination register
- ex_reg_w_en  in  1  ALU op writes rd
- ex_is_load  in  1  op is a load; ex_reg_w_en ignored when set
- ex_f3  in  3  load funct3
- ex_ofs  in  OFS_W  low address bits of load
- ex_alu_out  in  XLEN  ALU result
- mem_rsp_valid  in  1  load data valid; always accepted
- mem_rsp_data  in  XLEN  aligned word/doubleword from memory
- wb_en  out  1  register write strobe
- wb_reg  out  RA_W  write address
- wb_val  out  XLEN  write data
- pend_cnt  out  log2(DEPTH)+1  outstanding loads
- rsp_err  out  1  sticky: response arrived with no pending load

## Operation
- Accept = ex_valid & ex_ready.
- Pending queue: FIFO of {rd, f3, ofs}, DEPTH entries, pointers wrap modulo DEPTH.
- Load accept pushes an entry; load produces no write at issue.
- mem_rsp_valid with queue non-empty (count before this cycle's push) pops head and writes extended data to head.rd.
- mem_rsp_valid with queue empty: data dropped, no write, rsp_err set until rst.
- ex_ready deasserted when any holds:
  - ex_is_load and queue full (a same-cycle pop does not free the slot);
  - ALU write (ex_reg_w_en, !ex_is_load) and mem_rsp_valid same cycle (response has port priority);
  - ALU write with ex_rd ≠ 0 matching rd of any valid pending entry (WAW order).
- ex_valid with neither ex_is_load nor ex_reg_w_en is accepted whenever ex_ready=1 and has no effect.
- Writes to rd=0: wb_en forced 0; the load entry still occupies and pops the queue normally.
- Lane select: byte = data >> 8·ofs; half = data >> 16·ofs[OFS_W-1:1]; word (XLEN=64) = data >> 32·ofs[OFS_W-1]; misaligned low bits ignored.
- Extension by f3: 000 LB sign, 001 LH sign, 010 LW (sign when XLEN=64, full word when 32), 100 LBU zero, 101 LHU zero; 011 LD and 110 LWU zero-ext only when XLEN=64; any other f3 writes value 0 with wb_en still asserted.

## Timing
- Reset: wb_en=0, wb_reg=0, wb_val=0, queue empty, pend_cnt=0, rsp_err=0; ex_ready follows combinationally from the empty queue.
- ex_ready is combinational from ex_* inputs, mem_rsp_valid and queue state.
- ALU op accepted cycle N → wb_en/wb_reg/wb_val valid cycle N+1, one cycle wide.
- Response cycle M → write visible cycle M+1.
- Back-to-back writes every cycle supported; no bubbles inserted when no stall condition holds.
- Simultaneous load push and response pop: pend_cnt unchanged; a push to an empty queue is not eligible for a same-cycle response.
- pend_cnt registered, updated the cycle after push/pop.
- Reset mid-operation discards all pending entries; any later response for them raises rsp_err.

## Test plan
- ALU op rd=5, 0x1234_5678, accepted cycle 3 → cycle 4 wb_en=1, wb_reg=5, wb_val=0x12345678; rd=0 variant → wb_en=0.
- LB rd=7 ofs=2, response 0x0080_0000 two cycles later → wb_val=0xFFFFFF80; LBU same → 0x00000080; LH ofs=2 data 0x8001_0000 → 0xFFFF8001.
- Issue DEPTH loads without responses → ex_ready=0 on next load, pend_cnt=DEPTH; one response → load accepted next cycle.
- Pending load rd=9, ALU op rd=9 → ex_ready=0 until response written, then ALU write follows, final reg value = ALU result.
- ALU op and mem_rsp_valid same cycle → load data written first, ALU write one cycle later.
- mem_rsp_valid with empty queue → no wb_en, rsp_err=1 held; rst → rsp_err=0, pend_cnt=0.
